// File: rtl/commit_checker.sv
// ---------------------------------------------------------------------------
// commit_checker
//
// Shadow-state commit checker for the Processor. It keeps its own copy of
// the architectural register file and replays every committed ALU
// instruction through a golden model. Up to COMMIT_W slots retire per beat,
// and a later slot sees the results of earlier slots in the same beat. One
// cycle after each beat, the whole shadow file is compared against the
// Processor's committed registers. The committed PC sequence is also checked.
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   commit_valid   per-slot commit strobe, expected to be a prefix
//   commit_pc      slot k PC at [32k+31:32k]
//   commit_inst    slot k instruction word at [32k+31:32k]
//   arch_regs      Processor committed registers, reg i at [32i+31:32i]
//   state          0 IDLE, 1 RUN, 2 HALT, 3 DONE
//   err_count      erroring beats (data and/or PC), saturating
//   unsup_count    committed unsupported instructions, saturating
//   retired        instructions retired
//   first_err_reg  lowest mismatching register of the first erroring beat
//   first_err_pc   slot 0 PC of the first erroring beat
//   pc_err         sticky PC-sequence error
//   proto_err      sticky non-prefix commit_valid
//   pass, fail     sticky end-of-run verdict
// ---------------------------------------------------------------------------
module commit_checker #(
   parameter int          COMMIT_W    = 2,
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          TARGET      = 20000,
   parameter bit          STOP_ON_ERR = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [COMMIT_W-1:0]   commit_valid,
   input  logic [32*COMMIT_W-1:0] commit_pc,
   input  logic [32*COMMIT_W-1:0] commit_inst,
   input  logic [1023:0]         arch_regs,
   output logic [1:0]            state,
   output logic [15:0]           err_count,
   output logic [15:0]           unsup_count,
   output logic [31:0]           retired,
   output logic [4:0]            first_err_reg,
   output logic [31:0]           first_err_pc,
   output logic                  pc_err,
   output logic                  proto_err,
   output logic                  pass,
   output logic                  fail
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;

   state_t              cur_state;
   logic [31:0][31:0]   shadow;
   logic [31:0][31:0]   shadow_nxt;
   logic [31:0]         exp_pc;

   // Compare pipeline: what the beat sampled last edge needs checked now.
   logic                pend_valid;
   logic                pend_pc_err;
   logic                pend_last;
   logic [31:0]         pend_pc0;

   logic [2:0]          n;
   logic                proto_bad;
   logic                pc_bad;
   logic [2:0]          unsup_n;
   logic [31:0]         retired_nxt;
   logic [16:0]         unsup_sum;

   logic                data_mis;
   logic [4:0]          mis_reg;
   logic                beat_err;
   logic                halt_now;
   logic                done_now;
   logic                accept;
   logic                take_beat;

   assign state = cur_state;

   // Golden model for one beat. Slots are applied in ascending order to a
   // working copy of the shadow file, so a later slot reads the results of
   // earlier slots, and the highest slot writing a register wins. Invalid
   // slots beyond the valid prefix are never executed.
   always_comb begin : golden
      logic        prefix;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  dst;
      logic [15:0] imm;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        wr;
      n          = 3'd0;
      proto_bad  = 1'b0;
      pc_bad     = 1'b0;
      unsup_n    = 3'd0;
      shadow_nxt = shadow;
      prefix     = 1'b1;
      op         = 6'h0;
      fn         = 6'h0;
      rs         = 5'h0;
      rt         = 5'h0;
      rd         = 5'h0;
      dst        = 5'h0;
      imm        = 16'h0;
      a          = 32'h0;
      b          = 32'h0;
      res        = 32'h0;
      wr         = 1'b0;
      for (int k = 0; k < COMMIT_W; k++) begin
         prefix = prefix & commit_valid[k];
         if (!prefix && commit_valid[k]) begin
            proto_bad = 1'b1;
         end
         if (prefix) begin
            n   = 3'(k + 1);
            op  = commit_inst[32*k+26 +: 6];
            rs  = commit_inst[32*k+21 +: 5];
            rt  = commit_inst[32*k+16 +: 5];
            rd  = commit_inst[32*k+11 +: 5];
            imm = commit_inst[32*k    +: 16];
            fn  = commit_inst[32*k    +: 6];
            a   = shadow_nxt[rs];
            b   = shadow_nxt[rt];
            dst = rt;
            wr  = 1'b1;
            res = 32'h0;
            case (op)
               OP_ORI:  res = a | {16'h0, imm};
               OP_ANDI: res = a & {16'h0, imm};
               OP_XORI: res = a ^ {16'h0, imm};
               OP_ADDI: res = a + {{16{imm[15]}}, imm};
               OP_LUI:  res = {imm, 16'h0};
               OP_RTYPE: begin
                  dst = rd;
                  case (fn)
                     FN_ADD: res = a + b;
                     FN_SUB: res = a - b;
                     FN_AND: res = a & b;
                     FN_OR:  res = a | b;
                     FN_XOR: res = a ^ b;
                     FN_NOR: res = ~(a | b);
                     default: wr = 1'b0;
                  endcase
               end
               default: wr = 1'b0;
            endcase
            if (!wr) begin
               unsup_n = unsup_n + 3'd1;
            end else if (dst != 5'd0) begin
               shadow_nxt[dst] = res;
            end
            if (commit_pc[32*k +: 32] != exp_pc + 32'(4 * k)) begin
               pc_bad = 1'b1;
            end
         end
      end
   end

   assign retired_nxt = retired + 32'(n);
   assign unsup_sum   = {1'b0, unsup_count} + 17'(unsup_n);

   // Full-file compare of the shadow written last edge against the
   // Processor's registers. Scanning downward leaves the lowest mismatching
   // index in mis_reg. Register 0 is hard-wired and skipped.
   always_comb begin
      data_mis = 1'b0;
      mis_reg  = 5'd0;
      for (int i = 31; i >= 1; i--) begin
         if (shadow[i] != arch_regs[32*i +: 32]) begin
            data_mis = 1'b1;
            mis_reg  = 5'(i);
         end
      end
   end

   // A halting or finishing compare closes the run on this very edge, so a
   // beat arriving alongside it must not be absorbed.
   assign beat_err  = pend_valid && (data_mis || pend_pc_err);
   assign halt_now  = beat_err && STOP_ON_ERR;
   assign done_now  = pend_valid && pend_last && !halt_now;
   assign accept    = (cur_state == S_IDLE || cur_state == S_RUN) && !halt_now && !done_now;
   assign take_beat = accept && (n != 3'd0);

   // Single state register block: beat absorption updates the shadow file,
   // PC tracking and counters at the beat edge; the compare result, state
   // transitions and verdict land one edge later.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state     <= S_IDLE;
         shadow        <= '0;
         exp_pc        <= RESET_PC;
         pend_valid    <= 1'b0;
         pend_pc_err   <= 1'b0;
         pend_last     <= 1'b0;
         pend_pc0      <= 32'h0;
         err_count     <= 16'h0;
         unsup_count   <= 16'h0;
         retired       <= 32'h0;
         first_err_reg <= 5'h0;
         first_err_pc  <= 32'h0;
         pc_err        <= 1'b0;
         proto_err     <= 1'b0;
         pass          <= 1'b0;
         fail          <= 1'b0;
      end else begin
         pend_valid  <= take_beat;
         pend_pc_err <= take_beat && pc_bad;
         pend_last   <= take_beat && (retired_nxt >= 32'(TARGET));
         pend_pc0    <= commit_pc[31:0];

         if (accept) begin
            shadow      <= shadow_nxt;
            exp_pc      <= exp_pc + (32'(n) << 2);
            retired     <= retired_nxt;
            unsup_count <= unsup_sum[16] ? 16'hFFFF : unsup_sum[15:0];
            if (n != 3'd0 && pc_bad) begin
               pc_err <= 1'b1;
            end
            if (proto_bad) begin
               proto_err <= 1'b1;
            end
            if (cur_state == S_IDLE && n != 3'd0) begin
               cur_state <= S_RUN;
            end
         end

         // Data and PC errors of the same beat count once.
         if (beat_err) begin
            if (err_count != 16'hFFFF) begin
               err_count <= err_count + 16'd1;
            end
            if (err_count == 16'h0) begin
               first_err_reg <= mis_reg;
               first_err_pc  <= pend_pc0;
            end
         end

         if (halt_now) begin
            cur_state <= S_HALT;
            fail      <= 1'b1;
         end else if (done_now) begin
            cur_state <= S_DONE;
            if (err_count == 16'h0 && !beat_err) begin
               pass <= 1'b1;
            end else begin
               fail <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_commit_checker.sv
// ---------------------------------------------------------------------------
// tb_commit_checker
//
// Two checker instances share one stimulus stream: dut_a runs a long target
// and halts on the first error; dut_b has a target of 4 retirements and keeps
// counting errors. A directed vector table, hand-written multi-cycle
// sequences and a randomized run against an ISA-level reference model are
// applied in turn.
// ---------------------------------------------------------------------------
module tb_commit_checker;

   localparam logic [31:0] I_ORI_R1   = 32'h34011234;
   localparam logic [31:0] I_ADDI_R2  = 32'h2022FFFF;
   localparam logic [31:0] I_LUI_R3   = 32'h3C03ABCD;
   localparam logic [31:0] I_ORI_R33  = 32'h34630001;
   localparam logic [31:0] I_LW       = 32'h8C000000;
   localparam logic [31:0] I_ORI_R3_7 = 32'h34030007;
   localparam logic [31:0] I_ORI_R4   = 32'h34040005;
   localparam logic [31:0] I_ORI_R5   = 32'h34050006;
   localparam logic [31:0] I_ADDI_R0  = 32'h20000005;
   localparam logic [31:0] I_XOR_R3   = 32'h00611826;
   localparam logic [31:0] I_NOR_R1   = 32'h00000827;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    commit_valid = 2'b00;
   logic [63:0]   commit_pc = '0;
   logic [63:0]   commit_inst = '0;
   logic [1023:0] arch_regs = '0;

   logic [1:0]  a_state, b_state;
   logic [15:0] a_err, b_err, a_unsup, b_unsup;
   logic [31:0] a_retired, b_retired, a_fpc, b_fpc;
   logic [4:0]  a_freg, b_freg;
   logic        a_pcerr, b_pcerr, a_proto, b_proto, a_pass, b_pass, a_fail, b_fail;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   commit_checker #(.COMMIT_W(2), .RESET_PC(32'h0), .TARGET(20000), .STOP_ON_ERR(1'b1)) dut_a (
      .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_inst(commit_inst), .arch_regs(arch_regs), .state(a_state),
      .err_count(a_err), .unsup_count(a_unsup), .retired(a_retired),
      .first_err_reg(a_freg), .first_err_pc(a_fpc), .pc_err(a_pcerr),
      .proto_err(a_proto), .pass(a_pass), .fail(a_fail)
   );

   commit_checker #(.COMMIT_W(2), .RESET_PC(32'h0), .TARGET(4), .STOP_ON_ERR(1'b0)) dut_b (
      .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_inst(commit_inst), .arch_regs(arch_regs), .state(b_state),
      .err_count(b_err), .unsup_count(b_unsup), .retired(b_retired),
      .first_err_reg(b_freg), .first_err_pc(b_fpc), .pc_err(b_pcerr),
      .proto_err(b_proto), .pass(b_pass), .fail(b_fail)
   );

   typedef struct {
      logic [1:0]  valid;
      logic [31:0] pc0, pc1, i0, i1;
      logic [31:0] r1, r2, r3;
      logic [31:0] e_ret;
      logic [15:0] e_err, e_unsup;
      logic [1:0]  e_state;
      logic        e_proto;
   } vec_t;

   typedef enum int {
      M_ORI, M_ANDI, M_XORI, M_ADDI, M_LUI,
      M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_BAD
   } mnem_t;

   logic [31:0] mreg [32];

   function automatic vec_t mkVec(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                                  input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] r1,
                                  input logic [31:0] r2, input logic [31:0] r3, input logic [31:0] ret,
                                  input logic [15:0] err, input logic [15:0] uns, input logic [1:0] st,
                                  input logic pro);
      vec_t t;
      t.valid = v; t.pc0 = p0; t.pc1 = p1; t.i0 = i0; t.i1 = i1;
      t.r1 = r1; t.r2 = r2; t.r3 = r3;
      t.e_ret = ret; t.e_err = err; t.e_unsup = uns; t.e_state = st; t.e_proto = pro;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkDut(input string tag, input bit use_b, input logic [31:0] ret, input logic [15:0] err,
                           input logic [15:0] uns, input logic [1:0] st, input logic pce, input logic pro);
      checkOutput({tag, ".retired"}, use_b ? b_retired : a_retired, ret);
      checkOutput({tag, ".err_count"}, 32'(use_b ? b_err : a_err), 32'(err));
      checkOutput({tag, ".unsup_count"}, 32'(use_b ? b_unsup : a_unsup), 32'(uns));
      checkOutput({tag, ".state"}, 32'(use_b ? b_state : a_state), 32'(st));
      checkOutput({tag, ".pc_err"}, 32'(use_b ? b_pcerr : a_pcerr), 32'(pce));
      checkOutput({tag, ".proto_err"}, 32'(use_b ? b_proto : a_proto), 32'(pro));
   endtask

   task automatic checkVerdict(input string tag, input bit use_b, input logic ps, input logic fl);
      checkOutput({tag, ".pass"}, 32'(use_b ? b_pass : a_pass), 32'(ps));
      checkOutput({tag, ".fail"}, 32'(use_b ? b_fail : a_fail), 32'(fl));
   endtask

   task automatic checkFirst(input string tag, input bit use_b, input logic [4:0] r, input logic [31:0] pc);
      checkOutput({tag, ".first_err_reg"}, 32'(use_b ? b_freg : a_freg), 32'(r));
      checkOutput({tag, ".first_err_pc"}, use_b ? b_fpc : a_fpc, pc);
   endtask

   task automatic setArch(input int idx, input logic [31:0] val);
      arch_regs[32*idx +: 32] = val;
   endtask

   task automatic applyStimulus(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                                input logic [31:0] i0, input logic [31:0] i1);
      @(negedge clk);
      commit_valid = v;
      commit_pc    = {p1, p0};
      commit_inst  = {i1, i0};
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst          = 1'b1;
      commit_valid = 2'b00;
      arch_regs    = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [31:0] encode(input mnem_t m, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [15:0] imm);
      case (m)
         M_ORI:  return {6'h0D, rs, rt, imm};
         M_ANDI: return {6'h0C, rs, rt, imm};
         M_XORI: return {6'h0E, rs, rt, imm};
         M_ADDI: return {6'h08, rs, rt, imm};
         M_LUI:  return {6'h0F, rs, rt, imm};
         M_ADD:  return {6'h00, rs, rt, rd, 5'h0, 6'h20};
         M_SUB:  return {6'h00, rs, rt, rd, 5'h0, 6'h22};
         M_AND:  return {6'h00, rs, rt, rd, 5'h0, 6'h24};
         M_OR:   return {6'h00, rs, rt, rd, 5'h0, 6'h25};
         M_XOR:  return {6'h00, rs, rt, rd, 5'h0, 6'h26};
         M_NOR:  return {6'h00, rs, rt, rd, 5'h0, 6'h27};
         default: return imm[0] ? {6'h23, rs, rt, imm} : {6'h00, rs, rt, rd, 5'h0, 6'h21};
      endcase
   endfunction

   // Architectural meaning of one instruction, applied to the model file.
   task automatic modelSlot(input mnem_t m, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [15:0] imm, output bit bad);
      logic [31:0] a, b, v;
      int dst;
      a = mreg[rs];
      b = mreg[rt];
      v = 32'h0;
      dst = int'(rd);
      bad = 1'b0;
      case (m)
         M_ORI:  begin dst = int'(rt); v = a | 32'(imm); end
         M_ANDI: begin dst = int'(rt); v = a & 32'(imm); end
         M_XORI: begin dst = int'(rt); v = a ^ 32'(imm); end
         M_ADDI: begin dst = int'(rt); v = a + 32'($signed(imm)); end
         M_LUI:  begin dst = int'(rt); v = 32'(imm) * 32'h10000; end
         M_ADD:  v = a + b;
         M_SUB:  v = a - b;
         M_AND:  v = a & b;
         M_OR:   v = a | b;
         M_XOR:  v = a ^ b;
         M_NOR:  v = ~(a | b);
         default: bad = 1'b1;
      endcase
      if (!bad && dst != 0) mreg[dst] = v;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[10];
      logic [31:0] mpc, mret, lastpc0;
      logic [15:0] munsup;
      logic [1:0]  v;
      logic [31:0] pcs [2];
      logic [31:0] ins [2];
      mnem_t m;
      logic [4:0] rs, rt, rd;
      logic [15:0] imm;
      bit bad;
      int n;

      vecs[0] = mkVec(2'b11, 32'd0,  32'd4,  I_ORI_R1,  I_ADDI_R2, 32'h1234, 32'h1233, 32'h0,        32'd2, 16'd0, 16'd0, 2'd1, 1'b0);
      vecs[1] = mkVec(2'b11, 32'd8,  32'd12, I_LUI_R3,  I_ORI_R33, 32'h1234, 32'h1233, 32'h0,        32'd4, 16'd0, 16'd0, 2'd1, 1'b0);
      vecs[2] = mkVec(2'b00, 32'd0,  32'd0,  32'h0,     32'h0,     32'h1234, 32'h1233, 32'hABCD0001, 32'd4, 16'd0, 16'd0, 2'd1, 1'b0);
      vecs[3] = mkVec(2'b01, 32'd16, 32'd0,  I_LW,      32'h0,     32'h1234, 32'h1233, 32'hABCD0001, 32'd5, 16'd0, 16'd1, 2'd1, 1'b0);
      vecs[4] = mkVec(2'b10, 32'd20, 32'd24, I_ORI_R4,  I_ORI_R5,  32'h1234, 32'h1233, 32'hABCD0001, 32'd5, 16'd0, 16'd1, 2'd1, 1'b1);
      vecs[5] = mkVec(2'b01, 32'd20, 32'd0,  I_ADDI_R2, 32'h0,     32'h1234, 32'h1233, 32'hABCD0001, 32'd6, 16'd0, 16'd1, 2'd1, 1'b1);
      vecs[6] = mkVec(2'b11, 32'd24, 32'd28, I_ADDI_R0, I_XOR_R3,  32'h1234, 32'h1233, 32'hABCD0001, 32'd8, 16'd0, 16'd1, 2'd1, 1'b1);
      vecs[7] = mkVec(2'b00, 32'd0,  32'd0,  32'h0,     32'h0,     32'h1234, 32'h1233, 32'hABCD1235, 32'd8, 16'd0, 16'd1, 2'd1, 1'b1);
      vecs[8] = mkVec(2'b01, 32'd32, 32'd0,  I_NOR_R1,  32'h0,     32'h1234, 32'h1233, 32'hABCD1235, 32'd9, 16'd0, 16'd1, 2'd1, 1'b1);
      vecs[9] = mkVec(2'b00, 32'd0,  32'd0,  32'h0,     32'h0,     32'hFFFFFFFF, 32'h1233, 32'hABCD1235, 32'd9, 16'd0, 16'd1, 2'd1, 1'b1);

      doReset();
      checkDut("reset", 1'b0, 32'd0, 16'd0, 16'd0, 2'd0, 1'b0, 1'b0);
      checkVerdict("reset", 1'b0, 1'b0, 1'b0);
      checkFirst("reset", 1'b0, 5'd0, 32'h0);

      for (int i = 0; i < 10; i++) begin
         setArch(1, vecs[i].r1);
         setArch(2, vecs[i].r2);
         setArch(3, vecs[i].r3);
         applyStimulus(vecs[i].valid, vecs[i].pc0, vecs[i].pc1, vecs[i].i0, vecs[i].i1);
         checkDut($sformatf("vec%0d", i), 1'b0, vecs[i].e_ret, vecs[i].e_err, vecs[i].e_unsup,
                  vecs[i].e_state, 1'b0, vecs[i].e_proto);
      end

      // Data mismatch: dut_a halts and drops the next beat; dut_b keeps going.
      doReset();
      setArch(1, 32'h1235);
      setArch(2, 32'h1233);
      applyStimulus(2'b11, 32'd0, 32'd4, I_ORI_R1, I_ADDI_R2);
      checkDut("mis_beat", 1'b0, 32'd2, 16'd0, 16'd0, 2'd1, 1'b0, 1'b0);
      applyStimulus(2'b11, 32'd8, 32'd12, I_ORI_R4, I_ORI_R5);
      checkDut("mis_a", 1'b0, 32'd2, 16'd1, 16'd0, 2'd2, 1'b0, 1'b0);
      checkFirst("mis_a", 1'b0, 5'd1, 32'h0);
      checkVerdict("mis_a", 1'b0, 1'b0, 1'b1);
      checkDut("mis_b", 1'b1, 32'd4, 16'd1, 16'd0, 2'd1, 1'b0, 1'b0);
      applyStimulus(2'b00, 32'd0, 32'd0, 32'h0, 32'h0);
      checkDut("mis_b_done", 1'b1, 32'd4, 16'd2, 16'd0, 2'd3, 1'b0, 1'b0);
      checkVerdict("mis_b_done", 1'b1, 1'b0, 1'b1);
      checkFirst("mis_b_done", 1'b1, 5'd1, 32'h0);
      checkDut("mis_a_hold", 1'b0, 32'd2, 16'd1, 16'd0, 2'd2, 1'b0, 1'b0);

      // PC error on the first beat.
      doReset();
      setArch(1, 32'h1234);
      applyStimulus(2'b01, 32'h8, 32'h0, I_ORI_R1, 32'h0);
      checkDut("pc_beat", 1'b0, 32'd1, 16'd0, 16'd0, 2'd1, 1'b1, 1'b0);
      applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      checkDut("pc_a", 1'b0, 32'd1, 16'd1, 16'd0, 2'd2, 1'b1, 1'b0);
      checkFirst("pc_a", 1'b0, 5'd0, 32'h8);
      checkVerdict("pc_a", 1'b0, 1'b0, 1'b1);
      checkDut("pc_b", 1'b1, 32'd1, 16'd1, 16'd0, 2'd1, 1'b1, 1'b0);

      // Non-prefix valid: n = 0, expected PC must not move.
      doReset();
      applyStimulus(2'b10, 32'd0, 32'd4, I_ORI_R1, I_ADDI_R2);
      checkDut("proto", 1'b0, 32'd0, 16'd0, 16'd0, 2'd0, 1'b0, 1'b1);
      applyStimulus(2'b01, 32'd0, 32'd0, I_ORI_R1, 32'h0);
      checkDut("proto_next", 1'b0, 32'd1, 16'd0, 16'd0, 2'd1, 1'b0, 1'b1);

      // Clean run to TARGET with one unsupported instruction.
      doReset();
      applyStimulus(2'b11, 32'd0, 32'd4, I_ORI_R1, I_ADDI_R2);
      setArch(1, 32'h1234);
      setArch(2, 32'h1233);
      applyStimulus(2'b11, 32'd8, 32'd12, I_LW, I_ORI_R3_7);
      checkDut("pass_beat", 1'b1, 32'd4, 16'd0, 16'd1, 2'd1, 1'b0, 1'b0);
      setArch(3, 32'h7);
      applyStimulus(2'b00, 32'd0, 32'd0, 32'h0, 32'h0);
      checkDut("pass_b", 1'b1, 32'd4, 16'd0, 16'd1, 2'd3, 1'b0, 1'b0);
      checkVerdict("pass_b", 1'b1, 1'b1, 1'b0);
      checkVerdict("pass_a", 1'b0, 1'b0, 1'b0);
      applyStimulus(2'b01, 32'd16, 32'd0, I_ORI_R1, 32'h0);
      checkDut("pass_b_after", 1'b1, 32'd4, 16'd0, 16'd1, 2'd3, 1'b0, 1'b0);

      // Reset with a PC-erroring compare still pending.
      doReset();
      applyStimulus(2'b10, 32'd0, 32'd0, 32'h0, 32'h0);
      applyStimulus(2'b11, 32'd0, 32'd4, I_ORI_R1, I_ADDI_R2);
      setArch(1, 32'h1234);
      setArch(2, 32'h1233);
      applyStimulus(2'b11, 32'h100, 32'h104, I_LUI_R3, I_ORI_R33);
      checkDut("rst_pre", 1'b0, 32'd4, 16'd0, 16'd0, 2'd1, 1'b1, 1'b1);
      doReset();
      checkDut("rst_a", 1'b0, 32'd0, 16'd0, 16'd0, 2'd0, 1'b0, 1'b0);
      checkVerdict("rst_a", 1'b0, 1'b0, 1'b0);
      checkFirst("rst_a", 1'b0, 5'd0, 32'h0);
      checkDut("rst_b", 1'b1, 32'd0, 16'd0, 16'd0, 2'd0, 1'b0, 1'b0);
      applyStimulus(2'b01, 32'd0, 32'd0, I_ORI_R1, 32'h0);
      checkDut("rst_next", 1'b0, 32'd1, 16'd0, 16'd0, 2'd1, 1'b0, 1'b0);
      setArch(1, 32'h1234);
      applyStimulus(2'b00, 32'd0, 32'd0, 32'h0, 32'h0);
      checkDut("rst_cmp", 1'b0, 32'd1, 16'd0, 16'd0, 2'd1, 1'b0, 1'b0);

      // Randomized run against the ISA-level model, then a planted error.
      doReset();
      for (int r = 0; r < 32; r++) mreg[r] = 32'h0;
      mpc = 32'h0; mret = 32'h0; munsup = 16'h0; lastpc0 = 32'h0;
      for (int it = 0; it < 300; it++) begin
         n = (it == 299) ? 2 : int'($urandom_range(0, 2));
         for (int r = 0; r < 32; r++) setArch(r, mreg[r]);
         v = 2'b00;
         for (int k = 0; k < 2; k++) begin
            if (k < n) begin
               m   = mnem_t'($urandom_range(0, 11));
               rs  = 5'($urandom_range(0, 7));
               rt  = 5'($urandom_range(0, 7));
               rd  = 5'($urandom_range(0, 7));
               imm = 16'($urandom);
               ins[k] = encode(m, rs, rt, rd, imm);
               pcs[k] = mpc + 32'(4 * k);
               v[k]   = 1'b1;
               modelSlot(m, rs, rt, rd, imm, bad);
               if (bad) munsup = munsup + 16'd1;
            end else begin
               ins[k] = $urandom;
               pcs[k] = $urandom;
            end
         end
         if (n > 0) lastpc0 = mpc;
         mpc  = mpc + 32'(4 * n);
         mret = mret + 32'(n);
         applyStimulus(v, pcs[0], pcs[1], ins[0], ins[1]);
         checkDut($sformatf("rand%0d", it), 1'b0, mret, 16'd0, munsup, (mret != 0) ? 2'd1 : 2'd0, 1'b0, 1'b0);
      end
      for (int r = 0; r < 32; r++) setArch(r, mreg[r]);
      setArch(0, 32'hDEAD);
      setArch(5, mreg[5] ^ 32'h10);
      setArch(9, mreg[9] ^ 32'h1);
      applyStimulus(2'b00, 32'd0, 32'd0, 32'h0, 32'h0);
      checkDut("rand_err", 1'b0, mret, 16'd1, munsup, 2'd2, 1'b0, 1'b0);
      checkFirst("rand_err", 1'b0, 5'd5, lastpc0);
      checkVerdict("rand_err", 1'b0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/commit_checker.md
# commit_checker

Synthesizable multi-slot commit checker that runs alongside the Processor in simulation and emulation. It keeps a shadow architectural register file and replays each committed ALU instruction through a golden model, supporting up to COMMIT_W retirements per cycle with in-cycle dependencies. After every commit beat it checks the Processor's committed register file and the committed PC sequence, then reports pass, fail and first-error details. It replaces the testbench-only single-commit golden model.

## Interface
- COMMIT_W, 2: commit slots per cycle (1..4).
- RESET_PC, 32'h0: expected PC of the first commit.
- TARGET, 20000: retired-instruction count that ends the run.
- STOP_ON_ERR, 1: 1 = halt checking at the first error; 0 = keep counting.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- commit_valid  in  COMMIT_W  per-slot commit strobe; must be a prefix (slots 0..n-1).
- commit_pc  in  32*COMMIT_W  slot k PC at [32k+31:32k].
- commit_inst  in  32*COMMIT_W  slot k instruction word.
- arch_regs  in  1024  Processor committed registers; reg i at [32i+31:32i]; reg 0 ignored.
- state  out  2  0 IDLE, 1 RUN, 2 HALT, 3 DONE.
- err_count  out  16  mismatching compare cycles plus PC errors; saturates at 16'hFFFF.
- unsup_count  out  16  committed unsupported instructions; saturating.
- retired  out  32  instructions retired.
- first_err_reg  out  5  lowest mismatching register at the first data error.
- first_err_pc  out  32  PC of slot 0 of the first erroring beat.
- pc_err, proto_err  out  1 each  sticky flags.
- pass, fail  out  1 each  sticky end-of-run verdict.

## Operation
- Golden model, per slot in ascending k. Slot k reads the shadow state as already updated by slots 0..k-1 of the same beat.
  - ORI, ANDI, XORI: zero-extended immediate.
  - ADDI: sign-extended immediate, 32-bit wrap, no overflow trap.
  - LUI: {imm, 16'h0}.
  - R-type ADD, SUB, AND, OR, XOR, NOR: write rd.
  - Destination 0 is never written. If two slots write the same register, the highest slot wins.
- Unsupported opcode or funct:
  - No shadow write.
  - unsup_count +1 per such slot.
  - The PC still advances.
- Valid-slot count:
  - n = length of the valid prefix.
  - A non-prefix commit_valid (for example 2'b10) sets proto_err.
  - Only the prefix is used. A pattern with slot 0 invalid is treated as n = 0.
- PC check:
  - Slot k must carry exp_pc + 4k. Any mismatch sets pc_err and counts as one error for the beat.
  - exp_pc advances by 4n regardless of the check result.
  - retired advances by n.
- Data compare: in the cycle after a beat, all 31 shadow registers are compared to arch_regs.
  - Any mismatch: err_count +1, and a single combined error if pc_err also fired for that beat.
  - first_err_reg and first_err_pc are captured only while err_count==0.
- State machine:
  - IDLE → RUN on the first beat with n > 0.
  - RUN → HALT on any error when STOP_ON_ERR=1.
  - RUN → DONE when the compare of the beat that brings retired ≥ TARGET completes.
  - HALT and DONE are sticky until rst. Commits in these states are ignored.
- Verdict: on entering DONE, pass = (err_count==0); otherwise fail = 1. On entering HALT, fail = 1.

## Timing
- Reset values: all counters, flags, the shadow file and first_err_* are 0; state is IDLE; exp_pc = RESET_PC.
- Beat sampled at edge E:
  - Shadow file, exp_pc, retired, unsup_count, pc_err and proto_err update at E.
  - The data compare is registered at E+1: err_count, first_err_*, state and verdict.
- Back-to-back beats are fully pipelined. The compare for E+1 uses the shadow state written at E+1.
- A beat arriving at the same edge as a halting compare is ignored.
- rst asserted mid-run clears all state at that edge. Any pending compare is discarded.

## Test plan
- COMMIT_W=2, single beat:
  - Stimulus: slot0 pc 0 = 0x34011234 (ori r1,r0,0x1234); slot1 pc 4 = 0x2022FFFF (addi r2,r1,-1).
  - arch_regs r1=0x1234, r2=0x1233.
  - Required: err_count=0, retired=2, state RUN.
- Same-destination beat:
  - Stimulus: 0x3C03ABCD (lui r3) and 0x34630001 (ori r3,r3,1) in one beat.
  - Required: shadow r3 = 0xABCD0001; arch r3 = 0xABCD0001 gives no error.
- Data mismatch:
  - Stimulus: as the first scenario, but arch r1 = 0x1235.
  - Required at E+1: err_count=1, first_err_reg=1, first_err_pc=0, state HALT, fail=1.
  - A following beat leaves retired=2.
- PC and protocol errors:
  - Stimulus: slot0 pc 0x8 where 0x0 is expected.
  - Required: pc_err=1 and err_count=1.
  - Separately, commit_valid=2'b10 sets proto_err with n=0.
- Pass and unsupported:
  - Stimulus: TARGET=4; four correct commits including 0x8C000000 (lw).
  - Required: unsup_count=1, state DONE, pass=1, fail=0.
- Reset mid-run:
  - Stimulus: rst for one cycle after two beats.
  - Required: all outputs return to reset values, and the next commit is checked against pc 0.
